// File: rtl/washer_plant_responder_if.sv
// rtl/washer_plant_responder_if.sv - actuator commands and plant status between washer controller and plant model
interface washer_plant_responder_if;
    logic       door_lock;
    logic       motor_on;
    logic       fill_valve_on;
    logic       drain_valve_on;
    logic       filled;
    logic       drained;
    logic       detergent_added;
    logic       cycle_timeout;
    logic       spin_timeout;
    logic [7:0] water_level;
    logic       interlock_fault;

    modport master (
        output door_lock, motor_on, fill_valve_on, drain_valve_on,
        input  filled, drained, detergent_added, cycle_timeout, spin_timeout,
               water_level, interlock_fault
    );

    modport slave (
        input  door_lock, motor_on, fill_valve_on, drain_valve_on,
        output filled, drained, detergent_added, cycle_timeout, spin_timeout,
               water_level, interlock_fault
    );
endinterface

// File: rtl/washer_plant_responder.sv
// rtl/washer_plant_responder.sv - washer plant model: tub level, motor phase timer, detergent doser, door interlock
module washer_plant_responder #(
    parameter int LEVEL_FULL = 16,
    parameter int WASH_TICKS = 32,
    parameter int SPIN_TICKS = 16,
    parameter int DET_TICKS  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    washer_plant_responder_if.slave   bus
);
    localparam logic [7:0] FULL8 = LEVEL_FULL[7:0];
    localparam logic [7:0] WASH8 = WASH_TICKS[7:0];
    localparam logic [7:0] SPIN8 = SPIN_TICKS[7:0];
    localparam logic [7:0] DET8  = DET_TICKS[7:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WASH = 2'd1,
        ST_SPIN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] level_q, level_d;
    logic [7:0] run_cnt_q, run_cnt_d;
    logic [7:0] det_cnt_q, det_cnt_d;
    logic       cto_q, cto_d;
    logic       sto_q, sto_d;
    logic       det_add_q, det_add_d;
    logic       fault_q, fault_d;
    logic [7:0] run_inc;
    logic       det_cond;

    assign run_inc  = run_cnt_q + 8'd1;
    assign det_cond = bus.door_lock && (level_q == FULL8) && !bus.fill_valve_on
                      && !bus.drain_valve_on && !bus.motor_on;

    always_comb begin
        level_d = level_q;
        if (bus.drain_valve_on) begin
            if (level_q != 8'd0) level_d = level_q - 8'd1;
        end else if (bus.fill_valve_on) begin
            if (level_q != FULL8) level_d = level_q + 8'd1;
        end
    end

    // The IDLE-exit cycle is motor-on cycle 1; a pulse fires on the edge where the count reaches the tick limit.
    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        cto_d     = 1'b0;
        sto_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.motor_on) begin
                    run_cnt_d = 8'd1;
                    if (level_q != 8'd0) begin
                        cto_d   = (WASH8 == 8'd1);
                        state_d = (WASH8 == 8'd1) ? ST_DONE : ST_WASH;
                    end else begin
                        sto_d   = (SPIN8 == 8'd1);
                        state_d = (SPIN8 == 8'd1) ? ST_DONE : ST_SPIN;
                    end
                end
            end
            ST_WASH, ST_SPIN: begin
                if (!bus.motor_on) begin
                    state_d   = ST_IDLE;
                    run_cnt_d = 8'd0;
                end else begin
                    run_cnt_d = run_inc;
                    if (state_q == ST_WASH && run_inc == WASH8) begin
                        cto_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (state_q == ST_SPIN && run_inc == SPIN8) begin
                        sto_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!bus.motor_on) begin
                    state_d   = ST_IDLE;
                    run_cnt_d = 8'd0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                run_cnt_d = 8'd0;
            end
        endcase
    end

    // Counter parks at DET_TICKS so a held condition yields a single dose pulse.
    always_comb begin
        det_cnt_d = det_cnt_q;
        det_add_d = 1'b0;
        if (!det_cond) begin
            det_cnt_d = 8'd0;
        end else if (det_cnt_q != DET8) begin
            det_cnt_d = det_cnt_q + 8'd1;
            det_add_d = ((det_cnt_q + 8'd1) == DET8);
        end
    end

    always_comb begin
        fault_d = fault_q | (!bus.door_lock &&
                  (bus.motor_on || bus.fill_valve_on || bus.drain_valve_on));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            level_q   <= 8'd0;
            run_cnt_q <= 8'd0;
            det_cnt_q <= 8'd0;
            cto_q     <= 1'b0;
            sto_q     <= 1'b0;
            det_add_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            run_cnt_q <= run_cnt_d;
            det_cnt_q <= det_cnt_d;
            cto_q     <= cto_d;
            sto_q     <= sto_d;
            det_add_q <= det_add_d;
            fault_q   <= fault_d;
        end
    end

    assign bus.filled          = (level_q == FULL8);
    assign bus.drained         = (level_q == 8'd0);
    assign bus.water_level     = level_q;
    assign bus.cycle_timeout   = cto_q;
    assign bus.spin_timeout    = sto_q;
    assign bus.detergent_added = det_add_q;
    assign bus.interlock_fault = fault_q;
endmodule

// File: tb/tb_washer_plant_responder.sv
// tb/tb_washer_plant_responder.sv - self-checking bench for washer_plant_responder
module tb_washer_plant_responder;
    localparam int FULL = 16;
    localparam int WASH = 32;
    localparam int SPIN = 16;
    localparam int DET  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    washer_plant_responder_if bus();

    washer_plant_responder #(
        .LEVEL_FULL(FULL), .WASH_TICKS(WASH), .SPIN_TICKS(SPIN), .DET_TICKS(DET)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: level by clamped arithmetic, motor and dose timing by run lengths of consecutive qualifying cycles.
    int m_level, m_mrun, m_drun;
    bit m_spin, m_ct, m_st, m_det, m_fault;

    function automatic int clamp_level(int l, bit fill, bit drain);
        if (drain) return (l > 0) ? l - 1 : 0;
        if (fill)  return (l < FULL) ? l + 1 : FULL;
        return l;
    endfunction

    function automatic bit run_is_spin(int run, bit latched, int level);
        return (run == 0) ? (level == 0) : latched;
    endfunction

    function automatic bit dose_cond(int level);
        return bus.door_lock && level == FULL && !bus.fill_valve_on
               && !bus.drain_valve_on && !bus.motor_on;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_level <= 0; m_mrun <= 0; m_drun <= 0;
            m_spin <= 0; m_ct <= 0; m_st <= 0; m_det <= 0; m_fault <= 0;
        end else begin
            m_level <= clamp_level(m_level, bus.fill_valve_on, bus.drain_valve_on);
            m_mrun  <= bus.motor_on ? ((m_mrun < 1000) ? m_mrun + 1 : m_mrun) : 0;
            m_spin  <= run_is_spin(m_mrun, m_spin, m_level);
            m_ct    <= bus.motor_on && (m_mrun + 1 == WASH) && !run_is_spin(m_mrun, m_spin, m_level);
            m_st    <= bus.motor_on && (m_mrun + 1 == SPIN) &&  run_is_spin(m_mrun, m_spin, m_level);
            m_drun  <= dose_cond(m_level) ? ((m_drun < 1000) ? m_drun + 1 : m_drun) : 0;
            m_det   <= dose_cond(m_level) && (m_drun + 1 == DET);
            m_fault <= m_fault | (!bus.door_lock &&
                       (bus.motor_on || bus.fill_valve_on || bus.drain_valve_on));
        end
    end

    task automatic chk(string name, int got, int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    int ct_seen = 0, st_seen = 0, det_seen = 0;

    always @(negedge clk) begin
        chk("water_level", int'(bus.water_level), m_level);
        chk("filled", int'(bus.filled), int'(m_level == FULL));
        chk("drained", int'(bus.drained), int'(m_level == 0));
        chk("cycle_timeout", int'(bus.cycle_timeout), int'(m_ct));
        chk("spin_timeout", int'(bus.spin_timeout), int'(m_st));
        chk("detergent_added", int'(bus.detergent_added), int'(m_det));
        chk("interlock_fault", int'(bus.interlock_fault), int'(m_fault));
        chk("timeout_exclusive", int'(bus.cycle_timeout && bus.spin_timeout), 0);
        if (bus.cycle_timeout)   ct_seen <= ct_seen + 1;
        if (bus.spin_timeout)    st_seen <= st_seen + 1;
        if (bus.detergent_added) det_seen <= det_seen + 1;
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drive(bit dl, bit mo, bit fv, bit dv);
        bus.door_lock = dl; bus.motor_on = mo; bus.fill_valve_on = fv; bus.drain_valve_on = dv;
    endtask

    int snap;

    initial begin
        drive(0, 0, 0, 0);
        step(2);
        chk("rst_level", int'(bus.water_level), 0);
        chk("rst_drained", int'(bus.drained), 1);
        chk("rst_fault", int'(bus.interlock_fault), 0);
        rst_n = 1'b1;
        step(1);

        drive(1, 0, 1, 0);
        step(15);
        chk("fill_15", int'(bus.water_level), 15);
        chk("fill_15_filled", int'(bus.filled), 0);
        step(1);
        chk("fill_16", int'(bus.water_level), 16);
        chk("fill_16_filled", int'(bus.filled), 1);
        step(3);
        chk("fill_sat", int'(bus.water_level), 16);

        drive(1, 0, 0, 0);
        step(3);
        chk("det_early", int'(bus.detergent_added), 0);
        step(1);
        chk("det_pulse", int'(bus.detergent_added), 1);
        step(6);
        chk("det_once", det_seen, 1);

        drive(1, 1, 0, 0);
        step(31);
        chk("wash_31", int'(bus.cycle_timeout), 0);
        step(1);
        chk("wash_32", int'(bus.cycle_timeout), 1);
        step(5);
        chk("wash_once", ct_seen, 1);
        drive(1, 0, 0, 0);
        step(1);
        drive(1, 1, 0, 0);
        step(10);
        drive(1, 0, 0, 0);
        step(3);
        chk("abort_no_pulse", ct_seen, 1);
        drive(1, 1, 0, 0);
        step(31);
        chk("rerun_31", int'(bus.cycle_timeout), 0);
        step(1);
        chk("rerun_32", int'(bus.cycle_timeout), 1);
        drive(1, 0, 0, 0);
        step(1);

        drive(1, 0, 1, 1);
        step(15);
        chk("drain_15", int'(bus.water_level), 1);
        step(1);
        chk("drain_16", int'(bus.drained), 1);
        drive(1, 1, 0, 0);
        step(15);
        chk("spin_15", int'(bus.spin_timeout), 0);
        step(1);
        chk("spin_16", int'(bus.spin_timeout), 1);
        chk("spin_no_wash", ct_seen, 2);
        drive(1, 0, 0, 0);
        step(1);

        drive(0, 0, 1, 0);
        step(1);
        drive(1, 0, 0, 0);
        step(3);
        chk("fault_sticky", int'(bus.interlock_fault), 1);
        rst_n = 1'b0;
        #1;
        chk("fault_cleared", int'(bus.interlock_fault), 0);
        step(1);
        rst_n = 1'b1;
        step(1);

        drive(1, 0, 1, 0);
        step(16);
        chk("refill_16", int'(bus.water_level), 16);
        drive(1, 1, 0, 0);
        step(20);
        snap = ct_seen;
        rst_n = 1'b0;
        #1;
        chk("midrun_level", int'(bus.water_level), 0);
        chk("midrun_drained", int'(bus.drained), 1);
        chk("midrun_ct", int'(bus.cycle_timeout), 0);
        drive(1, 0, 0, 0);
        step(2);
        rst_n = 1'b1;
        step(15);
        chk("midrun_no_pulse", ct_seen, snap);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
